// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// This is a single-stage instruction fetch unit. The PC register drives the
// instruction memory address. The returned word is captured into ir on the
// next rising edge.
//
// Optional build macro: FETCH_PERF_EN
//   - defined:   fetch_cnt counts instructions loaded into ir (saturating).
//   - undefined: no counter is built, and fetch_cnt reads 16'h0000.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset, overrides all other inputs
//   enable       leaves IDLE and starts fetching
//   stall        holds PC/ir/ir_pc/ir_valid while in RUN
//   redirect     taken branch/jump: flush ir and load PC from redirect_pc
//   redirect_pc  redirect target
//   imem_addr    instruction memory address (= PC register)
//   imem_rdata   instruction word for imem_addr (combinational memory)
//   ir           registered instruction for decode
//   ir_pc        address ir was fetched from
//   ir_valid     ir holds a real fetched instruction
//   halted       high while in HALTED
//   fetch_cnt    fetched-instruction count
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | PC held, ir is NOP; waits for enable (redirect loads PC)
// RUN     | fetching one instruction per unstalled cycle
// HALTED  | HALT word captured; ir flushed next cycle, waits for redirect
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        stall,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] ir,
  output logic [7:0]  ir_pc,
  output logic        ir_valid,
  output logic        halted,
  output logic [15:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic        halted_q, halted_d;
  logic        load_fetch;
  logic        is_halt;

  assign is_halt = (imem_rdata[15:11] == 5'b00001);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    load_fetch = 1'b0;

    case (state_q)
      S_IDLE: begin
        ir_d       = 16'h0000;
        ir_valid_d = 1'b0;
        if (redirect) pc_d = redirect_pc;
        if (enable)   state_d = S_RUN;
      end

      S_RUN: begin
        // Priority: redirect, then stall, then HALT detection, then fetch.
        if (redirect) begin
          pc_d       = redirect_pc;
          ir_d       = 16'h0000;
          ir_valid_d = 1'b0;
        end else if (!stall) begin
          ir_d       = imem_rdata;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          load_fetch = 1'b1;
          if (is_halt) state_d = S_HALTED;
          else         pc_d    = pc_q + 8'd1;
        end
      end

      S_HALTED: begin
        // The HALT word remains visible for the entry cycle only. Stall is ignored here.
        if (redirect) begin
          pc_d       = redirect_pc;
          ir_d       = 16'h0000;
          ir_valid_d = 1'b0;
          state_d    = S_RUN;
        end else begin
          ir_d       = 16'h0000;
          ir_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    halted_d = (state_d == S_HALTED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      ir_pc_q    <= 8'h00;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign halted    = halted_q;

`ifdef FETCH_PERF_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_fetch && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 16'h0000;
    else        cnt_q <= cnt_d;
  end

  assign fetch_cnt = cnt_q;
`else
  logic unused_load_fetch;
  assign unused_load_fetch = load_fetch;
  assign fetch_cnt         = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n, enable, stall, redirect;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid, halted;
  logic [15:0] fetch_cnt;

  logic [15:0] mem [256];

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  instr_fetch #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .halted(halted), .fetch_cnt(fetch_cnt)
  );

  typedef struct {
    string       nm;
    logic [7:0]  addr;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        v;
    logic        h;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [15:0] exp_cnt = 16'h0000;

  // Monitor: compare the state after every edge with the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (imem_addr !== e.addr || ir !== e.ir || ir_pc !== e.ir_pc ||
          ir_valid !== e.v || halted !== e.h || fetch_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s: got addr=%h ir=%h ir_pc=%h v=%b h=%b cnt=%h, want addr=%h ir=%h ir_pc=%h v=%b h=%b cnt=%h",
                 e.nm, imem_addr, ir, ir_pc, ir_valid, halted, fetch_cnt,
                 e.addr, e.ir, e.ir_pc, e.v, e.h, e.cnt);
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the edge.
  task automatic step(input logic rn, input logic en, input logic st,
                      input logic rd, input logic [7:0] rpc, input string nm,
                      input logic [7:0] e_addr, input logic [15:0] e_ir,
                      input logic [7:0] e_irpc, input logic e_v,
                      input logic e_h, input logic fetched);
    exp_t e;
    @(negedge clk);
    rst_n = rn; enable = en; stall = st; redirect = rd; redirect_pc = rpc;
`ifdef FETCH_PERF_EN
    if (!rn) exp_cnt = 16'h0000;
    else if (fetched && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`else
    exp_cnt = 16'h0000;
`endif
    e.nm = nm; e.addr = e_addr; e.ir = e_ir; e.ir_pc = e_irpc;
    e.v = e_v; e.h = e_h; e.cnt = exp_cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0]  = 16'h1210;
    mem[1]  = 16'h1420;
    mem[23] = 16'h0800;

    rst_n = 1'b0; enable = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;

    //    rn en st rd rpc    name           addr   ir        irpc  v  h  fetched
    step(0, 0, 0, 0, 8'h00, "reset",       8'h00, 16'h0000, 8'h00, 0, 0, 0);
    step(1, 0, 0, 0, 8'h00, "idle_hold",   8'h00, 16'h0000, 8'h00, 0, 0, 0);
    step(1, 1, 0, 0, 8'h00, "enable",      8'h00, 16'h0000, 8'h00, 0, 0, 0);
    step(1, 0, 0, 0, 8'h00, "fetch0",      8'h01, 16'h1210, 8'h00, 1, 0, 1);
    step(1, 0, 0, 0, 8'h00, "fetch1",      8'h02, 16'h1420, 8'h01, 1, 0, 1);
    step(1, 0, 0, 0, 8'h00, "fetch2",      8'h03, 16'h1002, 8'h02, 1, 0, 1);
    step(1, 0, 0, 0, 8'h00, "fetch3",      8'h04, 16'h1003, 8'h03, 1, 0, 1);
    step(1, 0, 0, 0, 8'h00, "fetch4",      8'h05, 16'h1004, 8'h04, 1, 0, 1);
    for (int i = 0; i < 3; i++)
      step(1, 0, 1, 0, 8'h00, "stall_pc5", 8'h05, 16'h1004, 8'h04, 1, 0, 0);
    step(1, 0, 0, 0, 8'h00, "stall_rel",   8'h06, 16'h1005, 8'h05, 1, 0, 1);
    step(1, 0, 1, 1, 8'h09, "redir_stall", 8'h09, 16'h0000, 8'h05, 0, 0, 0);
    step(1, 0, 0, 0, 8'h00, "fetch9",      8'h0A, 16'h1009, 8'h09, 1, 0, 1);
    step(1, 0, 0, 1, 8'd23, "redir23",     8'd23, 16'h0000, 8'h09, 0, 0, 0);
    step(1, 0, 0, 0, 8'h00, "halt_cap",    8'd23, 16'h0800, 8'd23, 1, 1, 1);
    step(1, 0, 1, 0, 8'h00, "halt_flush",  8'd23, 16'h0000, 8'd23, 0, 1, 0);
    step(1, 1, 0, 0, 8'h00, "halt_en_ign", 8'd23, 16'h0000, 8'd23, 0, 1, 0);
    step(1, 0, 0, 1, 8'h0C, "halt_exit",   8'h0C, 16'h0000, 8'd23, 0, 0, 0);
    step(1, 0, 0, 0, 8'h00, "fetch12",     8'h0D, 16'h100C, 8'h0C, 1, 0, 1);
    step(1, 0, 0, 1, 8'hFE, "redirFE",     8'hFE, 16'h0000, 8'h0C, 0, 0, 0);
    step(1, 0, 0, 0, 8'h00, "fetchFE",     8'hFF, 16'h10FE, 8'hFE, 1, 0, 1);
    step(1, 0, 0, 0, 8'h00, "fetchFF",     8'h00, 16'h10FF, 8'hFF, 1, 0, 1);
    step(1, 0, 0, 0, 8'h00, "wrap_fetch0", 8'h01, 16'h1210, 8'h00, 1, 0, 1);
    step(0, 1, 1, 1, 8'h33, "reset_mid",   8'h00, 16'h0000, 8'h00, 0, 0, 0);
    step(1, 0, 0, 1, 8'h40, "idle_redir",  8'h40, 16'h0000, 8'h00, 0, 0, 0);
    step(1, 0, 0, 0, 8'h00, "idle_stay",   8'h40, 16'h0000, 8'h00, 0, 0, 0);
    step(1, 1, 0, 0, 8'h00, "enable2",     8'h40, 16'h0000, 8'h00, 0, 0, 0);
    step(1, 0, 0, 0, 8'h00, "fetch40",     8'h41, 16'h1040, 8'h40, 1, 0, 1);
    step(1, 0, 0, 0, 8'h00, "en_low_run",  8'h42, 16'h1041, 8'h41, 1, 0, 1);
    step(1, 0, 0, 1, 8'd23, "redir23b",    8'd23, 16'h0000, 8'h41, 0, 0, 0);
    step(1, 0, 0, 1, 8'h30, "redir_ovr_h", 8'h30, 16'h0000, 8'h41, 0, 0, 0);
    step(1, 0, 0, 1, 8'd23, "redir23c",    8'd23, 16'h0000, 8'h41, 0, 0, 0);
    step(1, 0, 1, 0, 8'h00, "stall_ovr_h", 8'd23, 16'h0000, 8'h41, 0, 0, 0);
    step(1, 0, 0, 0, 8'h00, "halt_cap2",   8'd23, 16'h0800, 8'd23, 1, 1, 1);
    step(0, 0, 0, 0, 8'h00, "reset_halt",  8'h00, 16'h0000, 8'h00, 0, 0, 0);

    @(negedge clk);
    rst_n = 1'b1; enable = 1'b0; stall = 1'b0; redirect = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL provide parameter RESET_PC, default 8'h00, PC value loaded on reset.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL provide port enable  input  1  start fetching from the IDLE state.
REQ-005 SHALL provide port stall  input  1  hold PC and IR this cycle.
REQ-006 SHALL provide port redirect  input  1  taken branch/jump; flush and reload PC.
REQ-007 SHALL provide port redirect_pc  input  8  target address for redirect.
REQ-008 SHALL provide port imem_addr  output  8  instruction memory address, equal to the PC register (combinational).
REQ-009 SHALL provide port imem_rdata  input  16  instruction word, combinational from imem_addr.
REQ-010 SHALL provide port ir  output  16  registered instruction for decode.
REQ-011 SHALL provide port ir_pc  output  8  address the instruction in ir was fetched from.
REQ-012 SHALL provide port ir_valid  output  1  ir holds a real fetched instruction.
REQ-013 SHALL provide port halted  output  1  high while in HALTED state.
REQ-014 SHALL provide port fetch_cnt  output  16  fetched-instruction count (see Configuration).

Function
REQ-015 SHALL implement states IDLE, RUN, HALTED, all encoded in registers.
REQ-016 IDLE: PC holds; ir=16'h0000 (NOP); ir_valid=0; enable=1 -> RUN on next edge; no fetch is captured in the cycle enable is sampled.
REQ-017 RUN, no stall, no redirect: ir<=imem_rdata, ir_pc<=PC, ir_valid<=1, PC<=PC+1; latency addr->ir is one cycle.
REQ-018 PC arithmetic SHALL be 8-bit modulo: 8'hFF+1 -> 8'h00, no flag.
REQ-019 RUN, stall=1, redirect=0: PC, ir, ir_pc, ir_valid SHALL all hold.
REQ-020 redirect=1 (RUN or HALTED) SHALL take priority over stall and HALT detection: PC<=redirect_pc, ir<=16'h0000, ir_valid<=0, state<=RUN.
REQ-021 HALT detection: in RUN with stall=0, redirect=0, imem_rdata[15:11]==5'b00001 -> ir captures the HALT word, ir_valid<=1, PC does NOT increment, state<=HALTED.
REQ-022 HALTED: PC holds; one cycle after entry ir<=16'h0000, ir_valid<=0 and held; halted=1; stall ignored; exit only via redirect or reset.
REQ-023 redirect in IDLE SHALL load PC<=redirect_pc only, state stays IDLE.
REQ-024 enable SHALL be ignored outside IDLE; deasserting enable does not stop RUN.

Reset
REQ-025 rst_n=0 sampled on any edge, in any state and mid-stall/redirect, SHALL force next cycle: state=IDLE, PC=RESET_PC, ir=16'h0000, ir_pc=8'h00, ir_valid=0, halted=0, fetch_cnt=16'h0000.
REQ-026 rst_n SHALL override every other input.

Configuration
REQ-027 Macro FETCH_PERF_EN defined: fetch_cnt increments by 1 on each cycle ir_valid is loaded with 1 (REQ-017, REQ-021), saturating at 16'hFFFF.
REQ-028 FETCH_PERF_EN undefined: counter logic absent, fetch_cnt tied to 16'h0000; all other behaviour identical.

Verification
REQ-029 Reset, RESET_PC=0, enable=1 one cycle, mem[0]=16'h1210, mem[1]=16'h1420 -> imem_addr 0,1,2 on successive RUN cycles; ir=16'h1210, ir_pc=0 one cycle after addr 0; ir_valid=1.
REQ-030 stall=1 for 3 cycles at PC=5 -> imem_addr stays 5, ir/ir_pc unchanged; release -> ir=mem[5], PC=6.
REQ-031 redirect=1, redirect_pc=8'h09, stall=1 same cycle -> next cycle imem_addr=8'h09, ir=16'h0000, ir_valid=0; following cycle ir=mem[9].
REQ-032 mem[23]=16'h0800 (HALT) -> ir=16'h0800, state HALTED, halted=1, imem_addr stays 23; next cycle ir=0, ir_valid=0; redirect to 8'h0C -> halted=0, fetch resumes at 12.
REQ-033 Start PC=8'hFE, run 3 cycles -> imem_addr FE, FF, 00; rst_n=0 mid-run -> IDLE, PC=RESET_PC, outputs at reset values.
REQ-034 FETCH_PERF_EN defined, 10 unstalled fetches with one redirect bubble -> fetch_cnt=10; undefined -> fetch_cnt=0 throughout.
